// File: rtl/estagio_id_desvio.sv
// IF/ID pipeline register with ID-stage hazard detection and branch/jump resolution.
// Drives stall, redirect select and redirect target back to the fetch stage.
module estagio_id_desvio #(
    parameter logic [31:0] NOP        = 32'h0000_0000,
    parameter int          CONT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           contador,
    input  logic [31:0]           instrucao,
    input  logic [31:0]           rs_data,
    input  logic [31:0]           rt_data,
    input  logic                  idex_mem_read,
    input  logic                  idex_reg_write,
    input  logic [4:0]            idex_dest,
    input  logic                  exmem_mem_read,
    input  logic [4:0]            exmem_dest,
    output logic                  hazard,
    output logic [1:0]            sel_pc,
    output logic [31:0]           pc_desvio,
    output logic                  bolha,
    output logic [31:0]           ifid_instrucao,
    output logic [31:0]           ifid_contador,
    output logic                  ifid_valido,
    output logic [CONT_WIDTH-1:0] cont_stall,
    output logic [CONT_WIDTH-1:0] cont_flush
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    function automatic logic [CONT_WIDTH-1:0] sat_inc(input logic [CONT_WIDTH-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    // dependence on a source register from an EX writer or a MEM load
    function automatic logic dep_ramo(input logic [4:0] r,
                                      input logic       ex_wr,
                                      input logic [4:0] ex_d,
                                      input logic       mem_ld,
                                      input logic [4:0] mem_d);
        return (ex_wr  && ex_d  != 5'd0 && ex_d  == r) ||
               (mem_ld && mem_d != 5'd0 && mem_d == r);
    endfunction

    logic [5:0]         op;
    logic [5:0]         funct;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic signed [31:0] desloc;
    logic               is_beq, is_bne, is_br, is_jr, is_jmp, uses_rt;
    logic               load_use, ramo_dep, iguais;

    assign op     = ifid_instrucao[31:26];
    assign rs     = ifid_instrucao[25:21];
    assign rt     = ifid_instrucao[20:16];
    assign funct  = ifid_instrucao[5:0];
    assign desloc = 32'(signed'(ifid_instrucao[15:0])) <<< 2;

    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_br   = is_beq | is_bne;
    assign is_jr   = (op == OP_R) && (funct == FN_JR);
    assign is_jmp  = (op == OP_J) || (op == OP_JAL);
    assign uses_rt = ((op == OP_R) && !is_jr) || is_br || (op == OP_SW);
    assign iguais  = (rs_data == rt_data);

    assign load_use = idex_mem_read && (idex_dest != 5'd0) &&
                      ((idex_dest == rs) || (uses_rt && idex_dest == rt));

    assign ramo_dep = (is_br || is_jr) &&
                      (dep_ramo(rs, idex_reg_write, idex_dest, exmem_mem_read, exmem_dest) ||
                       (is_br && dep_ramo(rt, idex_reg_write, idex_dest, exmem_mem_read, exmem_dest)));

    // ID stage: stall takes priority over any redirect
    always_comb begin
        hazard    = 1'b0;
        sel_pc    = 2'b00;
        pc_desvio = 32'd0;
        if (ifid_valido) begin
            hazard = load_use || ramo_dep;
            if (!hazard) begin
                if ((is_beq && iguais) || (is_bne && !iguais)) begin
                    sel_pc    = 2'b01;
                    pc_desvio = ifid_contador + 32'(desloc);
                end else if (is_jmp) begin
                    sel_pc    = 2'b10;
                    pc_desvio = {ifid_contador[31:28], ifid_instrucao[25:0], 2'b00};
                end else if (is_jr) begin
                    sel_pc    = 2'b11;
                    pc_desvio = rs_data;
                end
            end
        end
    end

    assign bolha = hazard;

    // IF/ID boundary: hold on stall, flush on redirect, otherwise advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ifid_instrucao <= NOP;
            ifid_contador  <= 32'd0;
            ifid_valido    <= 1'b0;
            cont_stall     <= '0;
            cont_flush     <= '0;
        end else if (hazard) begin
            cont_stall <= sat_inc(cont_stall);
        end else if (sel_pc != 2'b00) begin
            ifid_instrucao <= NOP;
            ifid_contador  <= 32'd0;
            ifid_valido    <= 1'b0;
            cont_flush     <= sat_inc(cont_flush);
        end else begin
            ifid_instrucao <= instrucao;
            ifid_contador  <= contador;
            ifid_valido    <= 1'b1;
        end
    end

endmodule
